hwpe_stream_tcdm_fifo_load_credit: RTL
======================================

HWPE_STREAM_TCDM_FIFO_LOAD_CREDIT -- requirements
Module: hwpe_stream_tcdm_fifo_load_credit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, TCDM data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, TCDM address width in bits.
REQ-003 Parameter FIFO_DEPTH, default 8, entries in each FIFO and maximum reserved response slots; SHALL be >= 2.
REQ-004 Parameter LATCH_FIFO, default 0, selects latch-based FIFO storage.
REQ-005 Ports (name  direction  width  meaning):
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear.
- slv_req_i  in  1  upstream load request.
- slv_gnt_o  out  1  upstream grant.
- slv_add_i  in  ADDR_WIDTH  upstream address.
- slv_r_data_o  out  DATA_WIDTH  response data to upstream.
- slv_r_valid_o  out  1  response valid to upstream.
- slv_r_ready_i  in  1  upstream accepts response.
- mst_req_o  out  1  TCDM request.
- mst_gnt_i  in  1  TCDM grant.
- mst_add_o  out  ADDR_WIDTH  TCDM address.
- mst_r_data_i  in  DATA_WIDTH  TCDM response data.
- mst_r_valid_i  in  1  TCDM response valid; arbitrary latency, in order.
- credit_o  out  $clog2(FIFO_DEPTH+1)  free response slots.
- idle_o  out  1  no request queued, none outstanding, no response stored.
- error_o  out  1  sticky protocol error.

Function
REQ-006 Request path SHALL be a FIFO of depth FIFO_DEPTH holding addresses; slv_gnt_o = request FIFO not full; push on slv_req_i & slv_gnt_o.
REQ-007 Pushed address SHALL appear on mst_add_o no earlier than the next cycle.
REQ-008 mst_req_o SHALL equal request FIFO non-empty AND credit > 0; mst_req_o SHALL NOT depend combinationally on mst_gnt_i.
REQ-009 Request FIFO pop SHALL occur on mst_req_o & mst_gnt_i.
REQ-010 Credit counter: decrement on grant, increment on response-FIFO pop (slv_r_valid_o & slv_r_ready_i) or discarded response; both in one cycle leaves it unchanged; SHALL stay in [0, FIFO_DEPTH].
REQ-011 Outstanding counter: +1 on grant, -1 on mst_r_valid_i; both in one cycle leaves it unchanged.
REQ-012 Response path SHALL be a FIFO of depth FIFO_DEPTH pushed on accepted mst_r_valid_i; credit guarantees it never overflows; response visible on slv_r_valid_o earliest the cycle after mst_r_valid_i.
REQ-013 clear_i SHALL empty both FIFOs in that cycle, set discard counter to outstanding count (including a grant in the clear cycle), and set credit to FIFO_DEPTH minus that count.
REQ-014 While discard counter > 0, each mst_r_valid_i SHALL be dropped (not pushed), decrement discard and outstanding counters, and increment credit.
REQ-015 idle_o = request FIFO empty & outstanding == 0 & response FIFO empty.
REQ-016 error_o SHALL set on mst_r_valid_i with outstanding == 0, or credit over/underflow attempt; cleared only by rst_i or clear_i.
REQ-017 Response order SHALL equal grant order; no reordering, no data loss outside clear_i.

Reset
REQ-018 rst_i SHALL empty both FIFOs; credit_o = FIFO_DEPTH; outstanding and discard counters = 0; error_o = 0; idle_o = 1; slv_gnt_o = 1 the cycle after release; mst_req_o = 0; slv_r_valid_o = 0.
REQ-019 rst_i asserted mid-transfer SHALL override clear_i and all pending events in that cycle.

Structure
REQ-020 Counter-width helper and default depth/width constants SHALL live in hwpe_stream_package.
REQ-021 Both FIFOs SHALL be instances of the codebase's generic stream FIFO, hwpe_stream_fifo; no other sub-module.

Verification
REQ-022 DEPTH=4, 6 back-to-back requests, mst_gnt_i=1, response latency 1, slv_r_ready_i=1 -> 6 responses in issue order, credit_o returns to 4, idle_o=1.
REQ-023 DEPTH=4, slv_r_ready_i=0, TCDM always grants -> exactly 4 grants, then mst_req_o=0 with credit_o=0; releasing ready for one cycle -> exactly one further grant.
REQ-024 DEPTH=4, 3 grants outstanding, clear_i pulse, 3 later responses -> none reach upstream, credit_o goes 1 -> 4, idle_o=1.
REQ-025 Grant and upstream pop in the same cycle at credit_o=2 -> credit_o stays 2.
REQ-026 mst_r_valid_i with nothing outstanding -> error_o=1 next cycle, held until clear_i.
REQ-027 rst_i asserted with 2 outstanding, 2 queued -> all outputs at REQ-018 values the following cycle.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package
// Shared constants and helpers for the hwpe_stream blocks.
//   HWPE_STREAM_DATA_WIDTH / HWPE_STREAM_ADDR_WIDTH : default TCDM widths
//   HWPE_STREAM_FIFO_DEPTH                          : default FIFO depth
//   cnt_width(depth)                                : bits needed to count 0..depth
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_DATA_WIDTH = 32;
    localparam int unsigned HWPE_STREAM_ADDR_WIDTH = 32;
    localparam int unsigned HWPE_STREAM_FIFO_DEPTH = 8;

    // Width of a counter that must hold every value from 0 up to depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hwpe_stream_fifo.sv
// hwpe_stream_fifo
// Generic first-word-fall-through stream FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : synchronous flush; wins over a push/pop in the same cycle
//   push         : write request, ignored while full
//   push_data    : write data
//   full         : no free entry
//   pop          : read acknowledge, ignored while empty
//   pop_data     : head entry (valid while !empty)
//   empty        : no stored entry
module hwpe_stream_fifo
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = HWPE_STREAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = HWPE_STREAM_FIFO_DEPTH,
    parameter int unsigned LATCH_FIFO = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // One write-enabled register per entry. LATCH_FIFO=1 drops the entry
    // reset so the array maps onto plain storage cells; with LATCH_FIFO=0
    // the entries are cleared so pop_data is deterministic out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (LATCH_FIFO != 0) begin : g_plain
                always_ff @(posedge clk_i) begin
                    if (do_push && wr_ptr_reg == PW'(gi)) mem_reg[gi] <= push_data;
                end
            end else begin : g_reset
                always_ff @(posedge clk_i) begin
                    if (rst_i)                                 mem_reg[gi] <= '0;
                    else if (do_push && wr_ptr_reg == PW'(gi)) mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/hwpe_stream_tcdm_fifo_load_credit.sv
// hwpe_stream_tcdm_fifo_load_credit
// Credit-based decoupling of a TCDM load port: upstream requests are queued
// in an address FIFO and only issued to the TCDM when a response slot is
// reserved, so the response FIFO can never overflow. clear_i flushes both
// FIFOs and silently drops the responses still owed for already-granted loads.
//   clk_i, rst_i, clear_i                  : clock, sync reset, sync soft clear
//   slv_req_i/slv_gnt_o/slv_add_i          : upstream request channel
//   slv_r_data_o/slv_r_valid_o/slv_r_ready_i : upstream response channel
//   mst_req_o/mst_gnt_i/mst_add_o          : TCDM request channel
//   mst_r_data_i/mst_r_valid_i             : TCDM in-order response channel
//   credit_o                               : free response slots
//   idle_o                                 : nothing queued, outstanding or stored
//   error_o                                : sticky protocol error
module hwpe_stream_tcdm_fifo_load_credit
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = HWPE_STREAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = HWPE_STREAM_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = HWPE_STREAM_FIFO_DEPTH,
    parameter int unsigned LATCH_FIFO = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             slv_req_i,
    output logic                             slv_gnt_o,
    input  logic [ADDR_WIDTH-1:0]            slv_add_i,
    output logic [DATA_WIDTH-1:0]            slv_r_data_o,
    output logic                             slv_r_valid_o,
    input  logic                             slv_r_ready_i,
    output logic                             mst_req_o,
    input  logic                             mst_gnt_i,
    output logic [ADDR_WIDTH-1:0]            mst_add_o,
    input  logic [DATA_WIDTH-1:0]            mst_r_data_i,
    input  logic                             mst_r_valid_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  credit_o,
    output logic                             idle_o,
    output logic                             error_o
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);

    logic          req_full, req_empty, resp_full, resp_empty;
    logic [CW-1:0] credit_reg, credit_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic          error_reg, error_next;
    logic          grant, resp_expected, resp_drop, resp_push, resp_pop;
    logic          credit_bad;
    int            credit_calc, out_calc;

    // Request issue depends only on registered state, never on mst_gnt_i.
    assign slv_gnt_o     = ~req_full;
    assign mst_req_o     = ~req_empty & (credit_reg != '0);
    assign grant         = mst_req_o & mst_gnt_i;
    assign slv_r_valid_o = ~resp_empty;
    assign resp_pop      = slv_r_valid_o & slv_r_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    // Responses owed to loads issued before a clear are dropped in order.
    assign resp_expected = mst_r_valid_i & (outstanding_reg != '0);
    assign resp_drop     = resp_expected & (discard_reg != '0);
    assign resp_push     = resp_expected & (discard_reg == '0);

    always_comb begin
        credit_calc      = int'(credit_reg) + int'(resp_pop) + int'(resp_drop) - int'(grant);
        out_calc         = int'(outstanding_reg) + int'(grant) - int'(resp_expected);
        credit_bad       = (credit_calc < 0) || (credit_calc > int'(FIFO_DEPTH));
        // An out-of-range credit update is refused and flagged.
        credit_next      = credit_bad ? credit_reg : CW'(credit_calc);
        outstanding_next = CW'(out_calc);
        discard_next     = discard_reg - CW'(resp_drop);
        error_next       = error_reg
                         | (mst_r_valid_i & (outstanding_reg == '0))
                         | credit_bad
                         | (resp_push & resp_full);
        if (clear_i) begin
            // Every load still owed by the TCDM, including one granted in
            // this very cycle, becomes a response to discard.
            discard_next = CW'(out_calc);
            credit_next  = CW'(int'(FIFO_DEPTH) - out_calc);
            error_next   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_reg      <= CW'(FIFO_DEPTH);
            outstanding_reg <= '0;
            discard_reg     <= '0;
            error_reg       <= 1'b0;
        end else begin
            credit_reg      <= credit_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            error_reg       <= error_next;
        end
    end

    assign credit_o = credit_reg;
    assign error_o  = error_reg;
    assign idle_o   = req_empty & (outstanding_reg == '0) & resp_empty;

    hwpe_stream_fifo #(
        .DATA_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LATCH_FIFO (LATCH_FIFO)
    ) i_req_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (slv_req_i),
        .push_data (slv_add_i),
        .full      (req_full),
        .pop       (grant),
        .pop_data  (mst_add_o),
        .empty     (req_empty)
    );

    hwpe_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LATCH_FIFO (LATCH_FIFO)
    ) i_resp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push      (resp_push),
        .push_data (mst_r_data_i),
        .full      (resp_full),
        .pop       (resp_pop),
        .pop_data  (slv_r_data_o),
        .empty     (resp_empty)
    );

endmodule
